// File: rtl/fir_pkg.sv
// Shared types and constants for the nibble-serial FIR host: FSM encoding,
// datapath widths and the PE frame length.
package fir_pkg;

  localparam int NIB_W        = 4;
  localparam int X_W          = 8;
  localparam int Y_W          = 16;
  localparam int PE_FRAME_LEN = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    STRB = 3'd1,
    P0   = 3'd2,
    P1   = 3'd3,
    P2   = 3'd4,
    P3   = 3'd5,
    GAP  = 3'd6
  } state_t;

  function automatic logic [NIB_W-1:0] nib_sel(input logic [Y_W-1:0] v, input logic [1:0] idx);
    return v[idx*NIB_W +: NIB_W];
  endfunction

endpackage

// File: rtl/fir_nib_host_if.sv
// Host-side streaming bus of fir_nib_host: sample input, result output and
// the flush / overrun status lines.
interface fir_nib_host_if;

  logic [fir_pkg::X_W-1:0] x_data;
  logic                    x_valid;
  logic                    x_ready;
  logic [fir_pkg::Y_W-1:0] bias;
  logic                    flush;
  logic [fir_pkg::Y_W-1:0] y_data;
  logic                    y_valid;
  logic                    y_ready;
  logic                    overrun;

  modport master (
    output x_data, x_valid, bias, flush, y_ready,
    input  x_ready, y_data, y_valid, overrun
  );

  modport slave (
    input  x_data, x_valid, bias, flush, y_ready,
    output x_ready, y_data, y_valid, overrun
  );

endinterface

// File: rtl/fir_nib_deser.sv
// Collects four Yout nibbles (low first) into a 16-bit result and publishes it
// on a held valid/ready port; a result arriving while the port is blocked is dropped.
module fir_nib_deser
  import fir_pkg::*;
(
  input  logic             clk,
  input  logic             nReset,
  input  logic             cap_en,
  input  logic             pub_en,
  input  logic [NIB_W-1:0] yout,
  input  logic             y_ready,
  output logic [Y_W-1:0]   y_data,
  output logic             y_valid,
  output logic             overrun
);

  // Three history stages; the fourth (top) nibble is taken straight from yout.
  logic [NIB_W-1:0] stage_reg [0:2];
  logic [Y_W-1:0]   candidate;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stage
      always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
          stage_reg[gi] <= '0;
        end else if (cap_en) begin
          if (gi == 2) stage_reg[gi] <= yout;
          else         stage_reg[gi] <= stage_reg[gi+1];
        end
      end
    end
  endgenerate

  assign candidate = {yout, stage_reg[2], stage_reg[1], stage_reg[0]};

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      y_data  <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (pub_en) begin
      if (!y_valid || y_ready) begin
        y_data  <= candidate;
        y_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fir_nib_host.sv
// Host end of the nibble-serial FIR chain: frames parallel samples onto Rdy/Xin/Yin
// and reassembles Yout results. Define FIR_NIB_HOST_CHK_EN to add the Vld timing checker (proto_err).
module fir_nib_host
  import fir_pkg::*;
#(
  parameter int LAT_FRAMES = 2,
  parameter int PER_MIN    = 5
) (
  input  logic             clk,
  input  logic             nReset,
  fir_nib_host_if.slave    bus,
  output logic             Rdy,
  output logic [NIB_W-1:0] Xin,
  output logic [NIB_W-1:0] Yin,
  input  logic [NIB_W-1:0] Yout,
  input  logic             Vld
`ifdef FIR_NIB_HOST_CHK_EN
  , output logic           proto_err
`endif
);

  localparam int               CNT_W    = $clog2(LAT_FRAMES + 1);
  localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(LAT_FRAMES);
  localparam int               GAP_LEN  = PER_MIN - PE_FRAME_LEN;
  localparam logic [3:0]       GAP_LAST = 4'(GAP_LEN - 1);

  state_t           state_reg, state_next;
  logic [X_W-1:0]   x_lat_reg;
  logic [Y_W-1:0]   b_lat_reg;
  logic             flush_frame_reg;
  logic [CNT_W-1:0] pending_reg;
  logic [CNT_W-1:0] prime_reg;
  logic [3:0]       gap_cnt_reg;
  logic             x_ready_reg;
  logic             accept;
  logic             start_flush;
  logic             cap_en;
  logic             pub_en;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    start_flush = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.x_valid && x_ready_reg) begin
          accept     = 1'b1;
          state_next = STRB;
        end else if (bus.flush && pending_reg != '0) begin
          start_flush = 1'b1;
          state_next  = STRB;
        end
      end
      STRB:    state_next = P0;
      P0:      state_next = P1;
      P1:      state_next = P2;
      P2:      state_next = P3;
      P3:      state_next = (GAP_LEN > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt_reg == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame bookkeeping: pending counts real samples still owed a result,
  // prime counts frames already through the chain since reset.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      x_lat_reg       <= '0;
      b_lat_reg       <= '0;
      flush_frame_reg <= 1'b0;
      pending_reg     <= '0;
      prime_reg       <= '0;
      gap_cnt_reg     <= '0;
    end else begin
      if (accept) begin
        x_lat_reg       <= bus.x_data;
        b_lat_reg       <= bus.bias;
        flush_frame_reg <= 1'b0;
      end else if (start_flush) begin
        x_lat_reg       <= '0;
        b_lat_reg       <= '0;
        flush_frame_reg <= 1'b1;
      end
      if (state_reg == STRB && !flush_frame_reg && pending_reg < LAT_C)
        pending_reg <= pending_reg + 1'b1;
      else if (state_reg == P3 && flush_frame_reg && pending_reg != '0)
        pending_reg <= pending_reg - 1'b1;
      if (state_reg == P3 && prime_reg < LAT_C)
        prime_reg <= prime_reg + 1'b1;
      gap_cnt_reg <= (state_reg == GAP) ? gap_cnt_reg + 4'd1 : 4'd0;
    end
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      Rdy         <= 1'b0;
      Xin         <= '0;
      Yin         <= '0;
      x_ready_reg <= 1'b0;
    end else begin
      Rdy         <= (state_next == STRB);
      x_ready_reg <= (state_next == IDLE);
      case (state_next)
        P0: begin Xin <= x_lat_reg[3:0]; Yin <= nib_sel(b_lat_reg, 2'd0); end
        P1: begin Xin <= x_lat_reg[7:4]; Yin <= nib_sel(b_lat_reg, 2'd1); end
        P2: begin Xin <= '0;             Yin <= nib_sel(b_lat_reg, 2'd2); end
        P3: begin Xin <= '0;             Yin <= nib_sel(b_lat_reg, 2'd3); end
        default: begin Xin <= '0; Yin <= '0; end
      endcase
    end
  end

  assign bus.x_ready = x_ready_reg;
  assign cap_en      = (state_reg == P0) || (state_reg == P1) ||
                       (state_reg == P2) || (state_reg == P3);
  assign pub_en      = (state_reg == P3) && (prime_reg >= LAT_C);

  fir_nib_deser u_deser (
    .clk     (clk),
    .nReset  (nReset),
    .cap_en  (cap_en),
    .pub_en  (pub_en),
    .yout    (Yout),
    .y_ready (bus.y_ready),
    .y_data  (bus.y_data),
    .y_valid (bus.y_valid),
    .overrun (bus.overrun)
  );

`ifdef FIR_NIB_HOST_CHK_EN
  logic [2:0] vld_cnt_reg;
  logic       proto_err_reg;

  // vld_cnt_reg holds the number of cycles since the last Rdy, 0 when idle.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      vld_cnt_reg   <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      if (Rdy)
        vld_cnt_reg <= 3'd1;
      else if (vld_cnt_reg != 3'd0 && vld_cnt_reg != 3'(PE_FRAME_LEN))
        vld_cnt_reg <= vld_cnt_reg + 3'd1;
      else
        vld_cnt_reg <= 3'd0;
      if (Vld != (vld_cnt_reg == 3'(PE_FRAME_LEN)))
        proto_err_reg <= 1'b1;
    end
  end

  assign proto_err = proto_err_reg;
`else
  logic unused_vld;
  assign unused_vld = Vld;
`endif

endmodule

// File: tb/tb_fir_nib_host.sv
// Scoreboard bench for fir_nib_host with a loopback PE-chain model
// (Yout of frame n = sample of frame n-2 times 3, Vld five cycles after Rdy).
module tb_fir_nib_host;

  logic       clk = 1'b0;
  logic       nReset;
  logic       Rdy;
  logic [3:0] Xin, Yin, Yout;
  logic       Vld;
`ifdef FIR_NIB_HOST_CHK_EN
  logic       proto_err;
`endif

  fir_nib_host_if bus();

  fir_nib_host #(.LAT_FRAMES(2), .PER_MIN(5)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus),
    .Rdy    (Rdy),
    .Xin    (Xin),
    .Yin    (Yin),
    .Yout   (Yout),
    .Vld    (Vld)
`ifdef FIR_NIB_HOST_CHK_EN
    , .proto_err (proto_err)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // PE chain model
  int          fcnt = 0;
  int          ph = 4;
  int          k = 99;
  int          cyc = 0;
  int          last_rdy = 0;
  bit          chk_period = 1'b0;
  int          vld_dly = 0;
  logic [7:0]  rec [64];
  logic [15:0] pval;
  logic [15:0] tmp;

  always @(negedge clk) begin
    cyc++;
    if (!nReset) begin
      fcnt = 0; ph = 4; k = 99; Yout = 4'h0; Vld = 1'b0;
    end else begin
      if (Rdy) begin
        if (chk_period && fcnt > 0) chk("frame_period", cyc - last_rdy, 6);
        last_rdy = cyc;
        if (fcnt >= 2) begin
          tmp  = {8'h00, rec[fcnt-2]};
          pval = tmp * 16'd3;
        end else begin
          pval = 16'h0000;
        end
        ph = 0; k = 0; fcnt++;
        Yout = 4'h0;
      end else begin
        if (k < 20) k++;
        if (ph < 4) begin
          Yout = pval[ph*4 +: 4];
          if (ph == 0) rec[fcnt-1][3:0] = Xin;
          if (ph == 1) rec[fcnt-1][7:4] = Xin;
          ph++;
        end else begin
          Yout = 4'h0;
        end
      end
      Vld = (k == 5 + vld_dly);
    end
  end

  // Result monitor: pops the scoreboard on every y handshake.
  always @(negedge clk) begin
    #2;
    if (nReset && bus.y_valid && bus.y_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result actual=%0h required=none", bus.y_data);
      end else begin
        chk("y_data", bus.y_data, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] x, input logic [15:0] b);
    int n;
    bus.x_data = x; bus.bias = b; bus.x_valid = 1'b1;
    n = 0;
    while (!bus.x_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", bus.x_ready, 1);
    if (!bus.x_ready) begin
      bus.x_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.x_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    nReset = 1'b0;
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] xe [4];
  logic [3:0] ye [4];

  initial begin
    xe = '{4'h5, 4'hA, 4'h0, 4'h0};
    ye = '{4'h4, 4'h3, 4'h2, 4'h1};
    nReset = 1'b0;
    bus.x_data = '0; bus.x_valid = 1'b0; bus.bias = '0;
    bus.flush = 1'b0; bus.y_ready = 1'b1;
    Yout = 4'h0; Vld = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_Rdy", Rdy, 0);
    chk("rst_Xin", Xin, 0);
    chk("rst_Yin", Yin, 0);
    chk("rst_x_ready", bus.x_ready, 0);
    chk("rst_y_valid", bus.y_valid, 0);
    chk("rst_y_data", bus.y_data, 0);
    chk("rst_overrun", bus.overrun, 0);
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);

    // Single frame layout
    send(8'hA5, 16'h1234);
    chk("strb_Rdy", Rdy, 1);
    chk("strb_x_ready", bus.x_ready, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("frame_Xin", Xin, xe[i]);
      chk("frame_Yin", Yin, ye[i]);
      chk("frame_Rdy", Rdy, 0);
      chk("frame_x_ready", bus.x_ready, 0);
    end
    @(negedge clk);
    chk("idle_x_ready", bus.x_ready, 1);
    chk("idle_Xin", Xin, 0);
    chk("idle_Yin", Yin, 0);

    // Continuous stream followed by flush drain
    reset_pulse();
    chk_period = 1'b1;
    exp_q.push_back(16'd3);
    exp_q.push_back(16'd6);
    exp_q.push_back(16'd9);
    exp_q.push_back(16'd12);
    for (int i = 1; i <= 4; i++) send(8'(i), 16'h0000);
    bus.flush = 1'b1;
    repeat (60) @(negedge clk);
    chk("flush_frame_count", fcnt, 6);
    chk("flush_idle_x_ready", bus.x_ready, 1);
    chk("flush_drained", exp_q.size(), 0);
    bus.flush = 1'b0;
    chk_period = 1'b0;

    // Overrun with the consumer stalled
    reset_pulse();
    bus.y_ready = 1'b0;
    exp_q.push_back(16'h0030);
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 16'h0000);
    repeat (8) @(negedge clk);
    chk("ovr_y_valid", bus.y_valid, 1);
    chk("ovr_y_data_held", bus.y_data, 16'h0030);
    chk("ovr_overrun", bus.overrun, 1);
    bus.y_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_y_valid_clr", bus.y_valid, 0);
    chk("ovr_sticky", bus.overrun, 1);

    // Reset during P1
    send(8'h20, 16'hFFFF);
    @(negedge clk);
    @(negedge clk);
    nReset = 1'b0;
    #1;
    chk("mid_Rdy", Rdy, 0);
    chk("mid_Xin", Xin, 0);
    chk("mid_Yin", Yin, 0);
    chk("mid_x_ready", bus.x_ready, 0);
    chk("mid_y_valid", bus.y_valid, 0);
    chk("mid_y_data", bus.y_data, 0);
    chk("mid_overrun", bus.overrun, 0);
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
    exp_q.push_back(16'h0063);
    for (int i = 1; i <= 3; i++) send(8'h20 + 8'(i), 16'h0000);
    repeat (12) @(negedge clk);
    chk("reprime_drained", exp_q.size(), 0);

`ifdef FIR_NIB_HOST_CHK_EN
    chk("proto_ok", proto_err, 0);
    vld_dly = 1;
    exp_q.push_back(16'h0066);
    send(8'h30, 16'h0000);
    repeat (10) @(negedge clk);
    chk("proto_late_vld", proto_err, 1);
    chk("proto_drained", exp_q.size(), 0);
    vld_dly = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
